// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour type and colour-bar table for the raster generator.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CLK_DIV  = 2;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb_t BAR_COLOUR [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter advanced on en&cin, with carry-out and active-low sync window.
module vga_axis_counter #(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_WIDTH = 96,
    parameter int W          = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cin,
    output logic [W-1:0] count,
    output logic         carry,
    output logic         sync_n
);

    logic [W-1:0] count_q, count_d;
    logic         at_end;

    always_comb begin
        at_end  = (count_q == W'(TOTAL - 1));
        carry   = en && cin && at_end;
        count_d = count_q;
        if (en && cin) begin
            count_d = at_end ? '0 : count_q + 1'b1;
        end
        sync_n = !((count_q >= W'(SYNC_START)) && (count_q < W'(SYNC_START + SYNC_WIDTH)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing with a one-pixel registered colour/sync stage toward the DAC.
// Define VGA_TEST_PATTERN_EN to add the test_mode colour-bar substitution.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CLK_DIV  = VGA_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic       test_mode,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          vga_clk_q, vga_clk_d;
    logic          pix_tick;
    logic [9:0]    h_cnt, v_cnt;
    logic          h_wrap, unused_v_wrap;
    logic          hs_pre, vs_pre, active;
    rgb_t          colour_q, colour_d;
    logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

    assign pix_tick = (div_q == DW'(CLK_DIV - 1));

    vga_axis_counter #(.TOTAL(H_TOTAL), .SYNC_START(H_ACTIVE + H_FP), .SYNC_WIDTH(H_SYNC), .W(10)) u_h_cnt (
        .clk(clk), .rst_n(rst_n), .en(pix_tick), .cin(1'b1),
        .count(h_cnt), .carry(h_wrap), .sync_n(hs_pre)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .SYNC_START(V_ACTIVE + V_FP), .SYNC_WIDTH(V_SYNC), .W(10)) u_v_cnt (
        .clk(clk), .rst_n(rst_n), .en(pix_tick), .cin(h_wrap),
        .count(v_cnt), .carry(unused_v_wrap), .sync_n(vs_pre)
    );

    assign active = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));

`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] bar_idx;
    assign bar_idx = h_cnt / 10'd80;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
`endif

    always_comb begin
        div_d     = pix_tick ? '0 : div_q + 1'b1;
        // vga_clk falls on the same edge that loads the output stage, so the DAC's rising edge sees stable data.
        vga_clk_d = (div_d >= DW'(CLK_DIV / 2));
        colour_d  = colour_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        if (pix_tick) begin
            hs_d      = hs_pre;
            vs_d      = vs_pre;
            blank_n_d = active;
            colour_d  = active ? rgb_t'({r_in, g_in, b_in}) : '0;
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode && active) begin
                colour_d = BAR_COLOUR[bar_idx[2:0]];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            vga_clk_q <= 1'b0;
            colour_q  <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            vga_clk_q <= vga_clk_d;
            colour_q  <= colour_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign x           = h_cnt;
    assign y           = v_cnt;
    assign vga_r       = colour_q.r;
    assign vga_g       = colour_q.g;
    assign vga_b       = colour_q.b;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = vga_clk_q;
    assign frame_start = pix_tick && (h_cnt == '0) && (v_cnt == '0);
    assign line_start  = pix_tick && (h_cnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a clock-count reference model (short vertical timing).
module tb_vga_timing_gen;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_ACTIVE = 8, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic       clk, rst_n, test_mode;
    logic [7:0] r_in, g_in, b_in;
    logic [9:0] x, y;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start, line_start;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in), .test_mode(test_mode),
        .x(x), .y(y), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .vga_clk(vga_clk), .frame_start(frame_start), .line_start(line_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int c = 0;     // clock edges since reset release
    int cyc = 0;   // clock edges since time zero
    int mode = 0;
    logic        pend = 1'b0;
    logic [26:0] pend_out, exp_out;   // {rgb, hs, vs, blank_n}
    int hs_fall = -1, vs_fall = -1;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

`ifdef VGA_TEST_PATTERN_EN
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    wire logic [50:0] dut_vec = {x, y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
                                 vga_clk, frame_start, line_start, vga_sync_n};

    function automatic int mx(int cc); return (cc / CLK_DIV) % H_TOTAL; endfunction
    function automatic int my(int cc); return (cc / CLK_DIV / H_TOTAL) % V_TOTAL; endfunction
    function automatic bit mtick(int cc); return (cc % CLK_DIV) == CLK_DIV - 1; endfunction

    function automatic logic [50:0] exp_vec();
        logic vclk, fs, ls;
        vclk = (c % CLK_DIV) >= CLK_DIV / 2;
        ls   = mtick(c) && mx(c) == 0;
        fs   = ls && my(c) == 0;
        return {10'(mx(c)), 10'(my(c)), exp_out, vclk, fs, ls, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic reset_model();
        c = 0; pend = 1'b0; exp_out = {24'h0, 1'b1, 1'b1, 1'b0};
        hs_fall = -1; vs_fall = -1;
    endtask

    task automatic drive();
        test_mode = 1'($urandom);
        case (mode)
            1:       begin r_in = 8'hFF; g_in = 8'h00; b_in = 8'h00; end
            2:       begin r_in = x[7:0]; g_in = 8'($urandom); b_in = 8'($urandom); end
            default: begin r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom); end
        endcase
    endtask

    // Pixel at (mx,my) is captured with the inputs present at its tick edge.
    task automatic load_pend();
        int px, py;
        logic act;
        logic [23:0] rgb;
        if (rst_n && mtick(c)) begin
            px  = mx(c); py = my(c);
            act = (px < H_ACTIVE) && (py < V_ACTIVE);
            rgb = act ? {r_in, g_in, b_in} : 24'h0;
`ifdef VGA_TEST_PATTERN_EN
            if (act && test_mode) rgb = bar_tab[px / 80];
`endif
            pend_out = {rgb,
                        !(px >= H_ACTIVE + H_FP && px < H_ACTIVE + H_FP + H_SYNC),
                        !(py >= V_ACTIVE + V_FP && py < V_ACTIVE + V_FP + V_SYNC),
                        act};
            pend = 1'b1;
        end
    endtask

    task automatic measure();
        if (hs_prev && !vga_hs) begin
            if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, H_TOTAL * CLK_DIV);
            else              chk("hs_first_fall_x", x, H_ACTIVE + H_FP + 1);
            hs_fall = cyc;
        end
        if (!hs_prev && vga_hs && hs_fall >= 0) chk("hs_low", cyc - hs_fall, H_SYNC * CLK_DIV);
        if (vs_prev && !vga_vs) begin
            if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, H_TOTAL * V_TOTAL * CLK_DIV);
            vs_fall = cyc;
        end
        if (!vs_prev && vga_vs && vs_fall >= 0) chk("vs_low", cyc - vs_fall, V_SYNC * H_TOTAL * CLK_DIV);
        hs_prev = vga_hs;
        vs_prev = vga_vs;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            c++;
            if (pend) begin exp_out = pend_out; pend = 1'b0; end
        end
        @(negedge clk);
        chk("outputs", 64'(dut_vec), 64'(exp_vec()));
        measure();
        drive();
        load_pend();
    endtask

    initial begin
        int fs_cnt, y_first;
        bit found;
        rst_n = 1'b0; test_mode = 1'b0; r_in = '0; g_in = '0; b_in = '0;
        reset_model();
        repeat (3) @(negedge clk);
        chk("reset_state", 64'(dut_vec), 64'(exp_vec()));
        rst_n = 1'b1;
        drive();
        load_pend();

        mode = 1; repeat (3000) step();
        mode = 2; repeat (3000) step();
        mode = 0; repeat (36000) step();

        found = 1'b0;
        for (int i = 0; i < 30000 && !found; i++) begin
            step();
            found = (mx(c) == 300) && (my(c) == 5);
        end
        chk("reset_point_reached", found, 1);

        rst_n = 1'b0;
        reset_model();
        #1;
        chk("async_reset", 64'(dut_vec), 64'(exp_vec()));
        repeat (5) step();
        rst_n = 1'b1;

        fs_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            fs_cnt += int'(frame_start);
        end
        chk("frame_start_once", fs_cnt, 1);

        y_first = -1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (y_first < 0 && y != 10'd0) y_first = c;
        end
        chk("y_hold_800_ticks", y_first, H_TOTAL * CLK_DIV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
